// File: rtl/brent_kung_32b.sv
// brent_kung_32b: 32-bit Brent-Kung prefix adder with combinational sum S and registered copy S_q.
`timescale 1ns/1ps
module brent_kung_32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [32:0] S,
    output logic [32:0] S_q
);
    localparam int N = 32;
    localparam int L = 9;
    logic [N-1:0] w_g [L+1];
    logic [N-1:0] w_p [L+1];
    logic [N:0]   r_s;
    assign w_g[0] = A & B;
    assign w_p[0] = A ^ B;
    // Levels 0..4 up-sweep (span 2^l), levels 5..8 down-sweep (span 8,4,2,1).
    genvar l, i;
    generate
        for (l = 0; l < L; l++) begin : g_lvl
            localparam int SP = (l < 5) ? (1 << l) : (1 << (L - 1 - l));
            for (i = 0; i < N; i++) begin : g_bit
                localparam bit UP = (l < 5) && (((i + 1) % (2 * SP)) == 0);
                localparam bit DN = (l >= 5) && (((i + 1) % SP) == 0) &&
                                    (((i + 1) % (2 * SP)) != 0) && (i > SP);
                if (UP || DN) begin : g_op
                    assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-SP]);
                    assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-SP];
                end else begin : g_pass
                    assign w_g[l+1][i] = w_g[l][i];
                    assign w_p[l+1][i] = w_p[l][i];
                end
            end
        end
    endgenerate
    assign S = {w_g[L][N-1], w_p[0] ^ {w_g[L][N-2:0], 1'b0}};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s <= '0;
        else        r_s <= S;
    end
    assign S_q = r_s;
endmodule

// File: tb/tb_brent_kung_32b.sv
// tb_brent_kung_32b: random and directed checks of S and S_q against plain 33-bit addition.
`timescale 1ns/1ps
module tb_brent_kung_32b;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [32:0] s, s_q;
    logic [32:0] q [$];
    logic [32:0] held;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    brent_kung_32b dut (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .S(s), .S_q(s_q));

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s a=%h b=%h got=%0d (%b) want=%0d (%b)", name, a, b, act, act, exp, exp);
        end
    endtask

    // Drive one operand pair mid-cycle, check S 1 ns later and queue the expected S_q.
    task automatic apply(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        #1;
        chk("S", s, model(x, y));
        if (mon_en) q.push_back(model(x, y));
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && q.size() > 0) chk("S_q", s_q, q.pop_front());
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("S_q_reset", s_q, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        apply(32'h0000_0000, 32'h0000_0000);
        apply(32'hFFFF_FFFF, 32'h0000_0001);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply(32'h8000_0000, 32'h8000_0000);
        apply(32'hAAAA_AAAA, 32'h5555_5555);
        apply(32'h5555_5555, 32'hAAAA_AAAB);
        apply(32'h0000_0001, 32'hFFFF_FFFF);
        apply(32'h7FFF_FFFF, 32'h0000_0001);
        for (int k = 0; k < 2000; k++) apply($urandom, $urandom);
        apply(32'hFFFF_FFFF, 32'h0000_0001);
        @(posedge clk);
        #3;
        chk("S_q_pre_reset", s_q, 33'h1_0000_0000);
        mon_en = 1'b0;
        q.delete();
        held = s;
        rst_n = 1'b0;
        #1;
        chk("S_q_async_clear", s_q, 33'h0);
        chk("S_during_reset", s, held);
        @(negedge clk);
        chk("S_q_held_reset", s_q, 33'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("S_q_after_release", s_q, model(32'hFFFF_FFFF, 32'h0000_0001));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
